// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
//
// Shared definitions for the PS/2 host-side blocks (transmitter, receiver and
// the ps2c glitch filter they share).
//
// Contents:
//   ps2_state_e        transmitter state encoding
//   PS2_FILTER_LEN     default ps2c glitch-filter depth (clk samples)
//   PS2_RTS_CYCLES     default request-to-send hold time (100 us @ 50 MHz)
//   PS2_TIMEOUT_CYCLES default watchdog length (15 ms @ 50 MHz)
//   odd_parity()       parity bit that makes the 9-bit {parity, data} odd
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RTS   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_DONE  = 3'd5
  } ps2_state_e;

  localparam int PS2_FILTER_LEN     = 8;
  localparam int PS2_RTS_CYCLES     = 5000;
  localparam int PS2_TIMEOUT_CYCLES = 750000;

  // PS/2 uses odd parity: the bit is 1 when the data byte has an even number
  // of ones, so that data plus parity always carries an odd count.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ---------------------------------------------------------------------------
// ps2_clk_filter
//
// Debounces the device-driven PS/2 clock and flags its falling edges. The
// raw pin is shifted into a FILTER_LEN-deep register; the filtered clock only
// changes once the whole register agrees, so short glitches are absorbed.
// Shared by the PS/2 transmitter and receiver.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high
//   ps2c_i       in   raw ps2c pin value
//   f_ps2c_o     out  filtered ps2c (registered)
//   fall_edge_o  out  1 in the cycle the filtered clock is about to drop
// ---------------------------------------------------------------------------
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_i,
  output logic f_ps2c_o,
  output logic fall_edge_o
);

  logic [FILTER_LEN-1:0] filter_q;
  logic [FILTER_LEN-1:0] filter_d;
  logic                  f_ps2c_q;
  logic                  f_ps2c_d;

  // Newest sample enters at the MSB.
  assign filter_d = {ps2c_i, filter_q[FILTER_LEN-1:1]};

  // Hysteresis: switch only on unanimous history, otherwise hold.
  always_comb begin
    f_ps2c_d = f_ps2c_q;
    if (&filter_q) begin
      f_ps2c_d = 1'b1;
    end else if (~|filter_q) begin
      f_ps2c_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filter_q <= '0;
      f_ps2c_q <= 1'b0;
    end else begin
      filter_q <= filter_d;
      f_ps2c_q <= f_ps2c_d;
    end
  end

  assign f_ps2c_o    = f_ps2c_q;
  assign fall_edge_o = f_ps2c_q & ~f_ps2c_d;

endmodule

// File: rtl/ps2_tx.sv
// ---------------------------------------------------------------------------
// ps2_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte to a keyboard or
// mouse over the shared open-drain ps2c/ps2d lines: request-to-send (ps2c
// held low), start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
// The device generates the clock; data is changed on each filtered falling
// edge of ps2c. tx_idle gates the neighbouring receiver so it never samples
// our own frame.
//
// Optional feature (macro PS2_TX_TIMEOUT_EN): a watchdog aborts the frame if
// the device stops clocking for TIMEOUT_CYCLES cycles while we wait for it
// (start/data/stop). The abort releases both lines and pulses tx_err_tick.
// Without the macro tx_err_tick is tied 0 and the block waits indefinitely.
//
// Handshake: wr_ps2 is a request sampled only while tx_idle=1; the byte on
// din is captured in that same cycle. Requests while busy are dropped, not
// queued. Exactly one of tx_done_tick / tx_err_tick pulses per accepted
// request unless reset intervenes.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high
//   wr_ps2        in   start request (sampled only in idle)
//   din[7:0]      in   byte to send
//   ps2c_in       in   ps2c pin value
//   ps2d_in       in   ps2d pin value (reserved for ack checking, unused)
//   ps2c_oe       out  1 = drive ps2c low (registered)
//   ps2d_oe       out  1 = drive ps2d low (registered)
//   tx_idle       out  1 while idle
//   tx_done_tick  out  one-cycle pulse when a frame completes
//   tx_err_tick   out  one-cycle pulse on watchdog abort
//   dbg_state_o   out  current FSM state, for observation only
// ---------------------------------------------------------------------------
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int RTS_CYCLES     = PS2_RTS_CYCLES,
  parameter int FILTER_LEN     = PS2_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick,
  output ps2_state_e dbg_state_o
);

  localparam int                RTS_W    = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
  localparam logic [RTS_W-1:0]  RTS_LOAD = RTS_W'(RTS_CYCLES - 1);
  localparam logic [RTS_W-1:0]  RTS_ONE  = RTS_W'(1);

  // ---------------------------------------------------------------------------
  // Clock filter / edge detect (runs in every state)
  // ---------------------------------------------------------------------------
  logic f_ps2c;
  logic fall_edge;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk         (clk),
    .reset       (reset),
    .ps2c_i      (ps2c_in),
    .f_ps2c_o    (f_ps2c),
    .fall_edge_o (fall_edge)
  );

  // The filtered level is for the receiver; the data pin is kept for a later
  // ack check. Neither is needed by this revision of the transmitter.
  logic unused_inputs;
  assign unused_inputs = f_ps2c ^ ps2d_in;

  // ---------------------------------------------------------------------------
  // FSM state and datapath registers
  // ---------------------------------------------------------------------------
  ps2_state_e       state_q;
  logic [RTS_W-1:0] cnt_q;       // request-to-send countdown
  logic [3:0]       n_q;         // bits remaining after the current one
  logic [8:0]       b_q;         // {parity, data}, shifted out LSB first
  logic             ps2c_oe_q;
  logic             ps2d_oe_q;
  logic             tx_idle_q;
  logic             done_q;

  // Waiting for the device: these are the states the watchdog covers.
  logic wait_dev;
  assign wait_dev = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_STOP);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int               WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
`else
  // No watchdog: the timeout length has no effect in this build.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      b_q       <= '0;
      ps2c_oe_q <= 1'b0;
      ps2d_oe_q <= 1'b0;
      tx_idle_q <= 1'b1;
      done_q    <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (wr_ps2) begin
            b_q       <= {odd_parity(din), din};
            cnt_q     <= RTS_LOAD;
            ps2c_oe_q <= 1'b1;
            tx_idle_q <= 1'b0;
            state_q   <= ST_RTS;
          end
        end

        // Our own low pulse on ps2c produces filtered edges here; they are
        // deliberately ignored.
        ST_RTS: begin
          if (cnt_q == '0) begin
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b1;     // start bit
            state_q   <= ST_START;
          end else begin
            cnt_q <= cnt_q - RTS_ONE;
          end
        end

        ST_START: begin
          if (fall_edge) begin
            n_q       <= 4'd8;
            ps2d_oe_q <= ~b_q[0];
            state_q   <= ST_DATA;
          end
        end

        // Nine bits leave from here: eight data bits then the parity bit.
        // The output for the next bit is taken from b_q[1] because the shift
        // lands in the same edge.
        ST_DATA: begin
          if (fall_edge) begin
            b_q <= {1'b0, b_q[8:1]};
            if (n_q == 4'd0) begin
              ps2d_oe_q <= 1'b0;   // stop bit: release the line
              state_q   <= ST_STOP;
            end else begin
              n_q       <= n_q - 4'd1;
              ps2d_oe_q <= ~b_q[1];
            end
          end
        end

        ST_STOP: begin
          if (fall_edge) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        ST_DONE: begin
          tx_idle_q <= 1'b1;
          state_q   <= ST_IDLE;
        end

        default: begin
          ps2c_oe_q <= 1'b0;
          ps2d_oe_q <= 1'b0;
          tx_idle_q <= 1'b1;
          state_q   <= ST_IDLE;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Reload on entry to start and on every device edge while waiting; a
      // device edge always wins over expiry in the same cycle. Placed after
      // the case so an abort overrides the state's own assignments.
      if ((state_q == ST_RTS && cnt_q == '0) || (wait_dev && fall_edge)) begin
        wd_q <= WD_LOAD;
      end else if (wait_dev) begin
        if (wd_q == '0) begin
          ps2c_oe_q <= 1'b0;
          ps2d_oe_q <= 1'b0;
          tx_idle_q <= 1'b1;
          err_q     <= 1'b1;
          state_q   <= ST_IDLE;
        end else begin
          wd_q <= wd_q - WD_ONE;
        end
      end
`endif
    end
  end

  assign ps2c_oe      = ps2c_oe_q;
  assign ps2d_oe      = ps2d_oe_q;
  assign tx_idle      = tx_idle_q;
  assign tx_done_tick = done_q;
  assign dbg_state_o  = state_q;

`ifdef PS2_TX_TIMEOUT_EN
  assign tx_err_tick = err_q;
`else
  logic unused_wait_dev;
  assign unused_wait_dev = wait_dev;
  assign tx_err_tick = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_tx
//
// Directed bench for ps2_tx. A device model drives ps2c (open-drain with the
// host's pull-down) and samples the ps2d line just before each falling edge:
// start, d0..d7, parity, stop. Expected frames are hand-written bit vectors
// pushed onto exp_q. Build with +define+PS2_TX_TIMEOUT_EN to cover the
// watchdog branch of test_stall.
// ---------------------------------------------------------------------------
module tb_ps2_tx;
  import ps2_pkg::*;

  localparam int RTS  = 5000;
  localparam int FLT  = 8;
  localparam int TMO  = 3000;
  localparam int HALF = 20;

  // ---------------------------------------------------------------------------
  // Clock / reset / pins
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c = 1'b1;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err_tick;
  ps2_state_e dbg_state;

  always #5 clk = ~clk;

  // Open-drain lines with pull-ups.
  assign ps2c_in = dev_c & ~ps2c_oe;
  assign ps2d_in = ~ps2d_oe;

  ps2_tx #(
    .RTS_CYCLES     (RTS),
    .FILTER_LEN     (FLT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c_in      (ps2c_in),
    .ps2d_in      (ps2d_in),
    .ps2c_oe      (ps2c_oe),
    .ps2d_oe      (ps2d_oe),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .tx_err_tick  (tx_err_tick),
    .dbg_state_o  (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [10:0] exp_q[$];
  logic        samp_q[$];

  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) done_cnt++;
    if (tx_err_tick === 1'b1)  err_cnt++;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device clock pulses; the data line is sampled just before each fall.
  task automatic dev_clocks(input int npulse, input bit glitch);
    for (int i = 0; i < npulse; i++) begin
      if (glitch) begin
        tick(8); dev_c = 1'b0; tick(3); dev_c = 1'b1; tick(HALF - 11);
      end else begin
        tick(HALF);
      end
      samp_q.push_back(ps2d_in);
      dev_c = 1'b0;
      tick(HALF);
      dev_c = 1'b1;
    end
  endtask

  // Request a frame and measure how many cycles ps2c is held low.
  task automatic begin_frame(input logic [7:0] b, output int rts_len);
    samp_q.delete();
    din    = b;
    wr_ps2 = 1'b1;
    tick(1);
    wr_ps2 = 1'b0;
    rts_len = 0;
    while (ps2c_oe === 1'b1 && rts_len < RTS + 100) begin
      rts_len++;
      tick(1);
    end
  endtask

  function automatic logic [10:0] collect();
    logic [10:0] v;
    v = '1;
    for (int i = 0; i < 11 && i < samp_q.size(); i++) v[i] = samp_q[i];
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    tick(3);
    total++;
    if ({ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick} !== 5'b00100) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 00100",
               {ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err_tick});
    end
    reset = 1'b0;
    tick(20);
    total++;
    if (tx_idle !== 1'b1 || ps2c_oe !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got idle=%b c_oe=%b want 1 0", tx_idle, ps2c_oe);
    end
  endtask

  task automatic test_frame(input logic [7:0] b, input logic par, input bit glitch);
    int rts_len;
    int d0;
    logic [10:0] got;
    logic [10:0] exp;
    d0 = done_cnt;
    exp_q.push_back({1'b1, par, b, 1'b0});
    begin_frame(b, rts_len);
    total++;
    if (rts_len !== RTS) begin
      bad++;
      $display("FAIL rts_len_%h: got %0d want %0d", b, rts_len, RTS);
    end
    total++;
    if (ps2d_oe !== 1'b1 || tx_idle !== 1'b0) begin
      bad++;
      $display("FAIL start_bit_%h: got d_oe=%b idle=%b want 1 0", b, ps2d_oe, tx_idle);
    end
    tick(50);
    dev_clocks(11, glitch);
    tick(30);
    got = collect();
    exp = exp_q.pop_front();
    total++;
    if (samp_q.size() != 11 || got !== exp) begin
      bad++;
      $display("FAIL frame_bits_%h: got %b want %b", b, got, exp);
    end
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL done_pulses_%h: got %0d want 1", b, done_cnt - d0);
    end
    total++;
    if ({ps2c_oe, ps2d_oe, tx_idle} !== 3'b001) begin
      bad++;
      $display("FAIL after_frame_%h: got %b want 001", b, {ps2c_oe, ps2d_oe, tx_idle});
    end
  endtask

  task automatic test_ignore_wr();
    int rts_len;
    int d0;
    logic [10:0] got;
    logic [10:0] exp;
    d0 = done_cnt;
    exp_q.push_back({1'b1, 1'b1, 8'hED, 1'b0});
    begin_frame(8'hED, rts_len);
    tick(50);
    dev_clocks(5, 1'b0);
    din = 8'h55; wr_ps2 = 1'b1; tick(1); wr_ps2 = 1'b0;
    dev_clocks(6, 1'b0);
    tick(30);
    got = collect();
    exp = exp_q.pop_front();
    total++;
    if (samp_q.size() != 11 || got !== exp) begin
      bad++;
      $display("FAIL busy_wr_frame: got %b want %b", got, exp);
    end
    tick(300);
    total++;
    if (tx_idle !== 1'b1 || ps2c_oe !== 1'b0 || done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL busy_wr_no_second: got idle=%b c_oe=%b done=%0d want 1 0 1",
               tx_idle, ps2c_oe, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int rts_len;
    int d0;
    d0 = done_cnt;
    begin_frame(8'h00, rts_len);
    tick(50);
    dev_clocks(5, 1'b0);   // start + 4 data bits; d4 = 0 now on the line
    total++;
    if (ps2d_oe !== 1'b1 || tx_idle !== 1'b0) begin
      bad++;
      $display("FAIL mid_data_before_reset: got d_oe=%b idle=%b want 1 0", ps2d_oe, tx_idle);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({ps2c_oe, ps2d_oe, tx_idle} !== 3'b001) begin
      bad++;
      $display("FAIL async_reset_release: got %b want 001", {ps2c_oe, ps2d_oe, tx_idle});
    end
    tick(2);
    reset = 1'b0;
    tick(50);
    total++;
    if (done_cnt - d0 !== 0 || tx_idle !== 1'b1 || ps2c_oe !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_done: got done=%0d idle=%b c_oe=%b want 0 1 0",
               done_cnt - d0, tx_idle, ps2c_oe);
    end
  endtask

  task automatic test_stall();
    int rts_len;
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    begin_frame(8'hF4, rts_len);
    tick(50);
    dev_clocks(4, 1'b0);   // start + d0..d2; d3 = 0 now on the line
`ifdef PS2_TX_TIMEOUT_EN
    for (int i = 0; i < TMO + 200 && err_cnt == e0; i++) tick(1);
    tick(20);
    total++;
    if (err_cnt - e0 !== 1) begin
      bad++;
      $display("FAIL timeout_err_pulses: got %0d want 1", err_cnt - e0);
    end
    total++;
    if ({ps2c_oe, ps2d_oe, tx_idle} !== 3'b001 || done_cnt - d0 !== 0) begin
      bad++;
      $display("FAIL timeout_release: got %b done=%0d want 001 0",
               {ps2c_oe, ps2d_oe, tx_idle}, done_cnt - d0);
    end
`else
    tick(TMO + 500);
    total++;
    if (dbg_state !== ST_DATA || tx_idle !== 1'b0 || ps2d_oe !== 1'b1) begin
      bad++;
      $display("FAIL stall_holds_data: got st=%0d idle=%b d_oe=%b want %0d 0 1",
               dbg_state, tx_idle, ps2d_oe, ST_DATA);
    end
    total++;
    if (err_cnt - e0 !== 0 || done_cnt - d0 !== 0) begin
      bad++;
      $display("FAIL stall_no_ticks: got err=%0d done=%0d want 0 0",
               err_cnt - e0, done_cnt - d0);
    end
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(20);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_frame(8'hF4, 1'b0, 1'b0);
    test_frame(8'h00, 1'b1, 1'b0);
    test_frame(8'hFF, 1'b1, 1'b0);
    test_ignore_wr();
    test_frame(8'hA5, 1'b1, 1'b1);   // glitches between real edges
    test_reset_mid_frame();
    test_stall();
    test_frame(8'h01, 1'b0, 1'b0);   // recovery after the stall scenario
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
